// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deser
// Description : Serial-in/parallel-out deserializer for the receive end of the
//               PISO bit link. Collects WIDTH serial bits into a word and
//               presents it in a valid/ready holding register. A word that
//               completes while the holding register is still occupied and
//               not being accepted is dropped and flagged with a sticky
//               overrun bit.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous, active-high reset
//               enable   - bit strobe, sample data_in this cycle
//               data_in  - serial data bit
//               clear    - synchronous frame restart (drops partial word,
//                          clears overrun)
//               ready    - downstream accepts data_out this cycle
//               data_out - assembled word (holding register)
//               valid    - data_out holds an unconsumed word
//               busy     - partial word in progress
//               overrun  - sticky, a completed word was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             data_in,
  input  logic             clear,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int               c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   r_shift;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0]   w_shift_next;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic               w_sample;
  logic               w_complete;
  logic               w_free;
  logic               w_load;
  logic               w_drop;

  // Shift direction is fixed at elaboration. LSB-first shifts right so the
  // first received bit ends up in bit 0 once the word is complete.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shift_next = {data_in, r_shift[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], data_in};
    end
  endgenerate

  // clear takes priority over enable: the bit presented with clear is ignored.
  assign w_sample   = enable & ~clear;
  assign w_complete = w_sample & (r_cnt == c_LAST);

  // The holding register can take a new word when empty, or when its current
  // word is being accepted on this same edge.
  assign w_free = ~valid | ready;
  assign w_load = w_complete & w_free;
  assign w_drop = w_complete & ~w_free;

  always_comb begin
    w_cnt_next = r_cnt;
    if (clear) begin
      w_cnt_next = '0;
    end else if (enable) begin
      w_cnt_next = (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
    end
  end

  // Serial assembly side: shift register, bit counter, overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      busy  <= (w_cnt_next != '0);
      if (clear) begin
        r_shift <= '0;
        overrun <= 1'b0;
      end else if (enable) begin
        r_shift <= w_shift_next;
        if (w_drop) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Holding register side: load takes precedence over a plain transfer so a
  // back-to-back word keeps valid high and replaces data_out. A completed
  // word is captured from w_shift_next so it includes the current bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      if (w_load) begin
        data_out <= w_shift_next;
        valid    <= 1'b1;
      end else if (valid & ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
